// File: rtl/neuron_layer_sequencer.sv
// neuron_layer_sequencer
//
// Time-multiplexes a single neuron datapath across every output of a
// fully-connected layer. For each output neuron k the sequencer resets the
// neuron, streams all N_INPUTS pixel/weight pairs out of synchronous-read
// memories, holds that neuron's bias, captures the 8-bit result into a result
// buffer and keeps a running argmax. At the end of a pass it reports the
// winning class together with a one-cycle done pulse.
//
// Ports
//   clk, reset              clock, synchronous active-high reset
//   start                   begin a layer pass (only looked at in IDLE)
//   busy / done / error     status: not IDLE / end-of-pass pulse / timeout flag
//   pix_addr, pix_rdata     pixel memory (read data one cycle after address)
//   w_addr, w_rdata         weight memory, address k*N_INPUTS + i
//   b_addr, b_rdata         bias memory, address k
//   n_reset, n_inp_ready,
//   n_inp_data, n_weight,
//   n_bias                  drive side of the shared neuron
//   n_out, n_out_ready      neuron result and its strobe
//   res_we/addr/data        result buffer write port
//   class_idx, class_score  argmax of the most recent pass

module neuron_layer_sequencer #(
    parameter int N_INPUTS  = 784,
    parameter int N_NEURONS = 10,
    parameter int PIX_AW    = 10,
    parameter int W_AW      = 13,
    parameter int IDX_W     = 4,
    parameter int TIMEOUT   = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic              error,
    output logic [PIX_AW-1:0] pix_addr,
    input  logic [15:0]       pix_rdata,
    output logic [W_AW-1:0]   w_addr,
    input  logic [15:0]       w_rdata,
    output logic [IDX_W-1:0]  b_addr,
    input  logic [15:0]       b_rdata,
    output logic              n_reset,
    output logic              n_inp_ready,
    output logic [15:0]       n_inp_data,
    output logic [15:0]       n_weight,
    output logic [15:0]       n_bias,
    input  logic [7:0]        n_out,
    input  logic              n_out_ready,
    output logic              res_we,
    output logic [IDX_W-1:0]  res_addr,
    output logic [7:0]        res_data,
    output logic [IDX_W-1:0]  class_idx,
    output logic [7:0]        class_score
);

    // state    | meaning
    // ---------+----------------------------------------------------------
    // S_IDLE   | waiting for start; class_* hold the last pass result
    // S_CLEAR  | one cycle: neuron held in reset, bias address presented
    // S_STREAM | N_INPUTS cycles issuing pixel/weight addresses i = 0..N-1
    // S_DRAIN  | one cycle: last pair reaches the neuron
    // S_WAIT   | waiting for n_out_ready, bounded by the TIMEOUT down-counter
    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_CLEAR  = 3'd1;
    localparam logic [2:0] S_STREAM = 3'd2;
    localparam logic [2:0] S_DRAIN  = 3'd3;
    localparam logic [2:0] S_WAIT   = 3'd4;

    localparam int TMR_W = $clog2(TIMEOUT + 1);

    localparam logic [PIX_AW-1:0] I_LAST    = PIX_AW'(N_INPUTS - 1);
    localparam logic [IDX_W-1:0]  K_LAST    = IDX_W'(N_NEURONS - 1);
    localparam logic [W_AW-1:0]   BASE_STEP = W_AW'(N_INPUTS);
    localparam logic [TMR_W-1:0]  TMR_LOAD  = TMR_W'(TIMEOUT - 1);

    logic [2:0]        state_q, state_d;
    logic [IDX_W-1:0]  k_q, k_d;
    logic [PIX_AW-1:0] i_q, i_d;
    logic [W_AW-1:0]   base_q, base_d;
    logic [TMR_W-1:0]  tmr_q, tmr_d;
    logic [7:0]        score_q, score_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [7:0]        class_score_q, class_score_d;
    logic [IDX_W-1:0]  class_idx_q, class_idx_d;
    logic [15:0]       bias_q, bias_d;
    logic              error_q, error_d;
    logic              done_q, done_d;
    logic              inp_ready_q;

    logic              capture;
    logic [7:0]        upd_score;
    logic [IDX_W-1:0]  upd_idx;

    assign capture = (state_q == S_WAIT) && n_out_ready;

    // Strictly-greater compare: on a tie the earlier (lower) index is kept.
    always_comb begin
        upd_score = score_q;
        upd_idx   = idx_q;
        if (n_out > score_q) begin
            upd_score = n_out;
            upd_idx   = k_q;
        end
    end

    always_comb begin
        state_d       = state_q;
        k_d           = k_q;
        i_d           = i_q;
        base_d        = base_q;
        tmr_d         = tmr_q;
        score_d       = score_q;
        idx_d         = idx_q;
        class_score_d = class_score_q;
        class_idx_d   = class_idx_q;
        bias_d        = bias_q;
        error_d       = error_q;
        done_d        = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_CLEAR;
                    k_d     = '0;
                    base_d  = '0;
                    score_d = '0;
                    idx_d   = '0;
                    error_d = 1'b0;
                end
            end

            S_CLEAR: begin
                state_d = S_STREAM;
                i_d     = '0;
            end

            S_STREAM: begin
                // Bias read was issued during CLEAR, so it is on b_rdata now.
                if (i_q == '0) begin
                    bias_d = b_rdata;
                end
                if (i_q == I_LAST) begin
                    state_d = S_DRAIN;
                end else begin
                    i_d = i_q + 1'b1;
                end
            end

            S_DRAIN: begin
                state_d = S_WAIT;
                tmr_d   = TMR_LOAD;
            end

            S_WAIT: begin
                if (n_out_ready) begin
                    score_d = upd_score;
                    idx_d   = upd_idx;
                    if (k_q == K_LAST) begin
                        state_d       = S_IDLE;
                        class_score_d = upd_score;
                        class_idx_d   = upd_idx;
                        done_d        = 1'b1;
                    end else begin
                        state_d = S_CLEAR;
                        k_d     = k_q + 1'b1;
                        base_d  = base_q + BASE_STEP;
                    end
                end else if (tmr_q == '0) begin
                    // Give up on this neuron; report the partial argmax.
                    state_d       = S_IDLE;
                    error_d       = 1'b1;
                    done_d        = 1'b1;
                    class_score_d = score_q;
                    class_idx_d   = idx_q;
                end else begin
                    tmr_d = tmr_q - 1'b1;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= S_IDLE;
            k_q           <= '0;
            i_q           <= '0;
            base_q        <= '0;
            tmr_q         <= '0;
            score_q       <= '0;
            idx_q         <= '0;
            class_score_q <= '0;
            class_idx_q   <= '0;
            bias_q        <= '0;
            error_q       <= 1'b0;
            done_q        <= 1'b0;
            inp_ready_q   <= 1'b0;
        end else begin
            state_q       <= state_d;
            k_q           <= k_d;
            i_q           <= i_d;
            base_q        <= base_d;
            tmr_q         <= tmr_d;
            score_q       <= score_d;
            idx_q         <= idx_d;
            class_score_q <= class_score_d;
            class_idx_q   <= class_idx_d;
            bias_q        <= bias_d;
            error_q       <= error_d;
            done_q        <= done_d;
            // Memory read data lags the address by one cycle, so the neuron
            // strobe is the issue strobe delayed by one.
            inp_ready_q   <= (state_q == S_STREAM);
        end
    end

    assign busy        = (state_q != S_IDLE);
    assign done        = done_q;
    assign error       = error_q;

    assign pix_addr    = i_q;
    assign w_addr      = base_q + W_AW'(i_q);
    assign b_addr      = k_q;

    assign n_reset     = reset | (state_q == S_CLEAR);
    assign n_inp_ready = inp_ready_q;
    assign n_inp_data  = pix_rdata;
    assign n_weight    = w_rdata;
    assign n_bias      = bias_q;

    // Gated by reset so an abort in the capture cycle never writes a result.
    assign res_we      = capture & ~reset;
    assign res_addr    = k_q;
    assign res_data    = n_out;

    assign class_idx   = class_idx_q;
    assign class_score = class_score_q;

endmodule

// File: tb/tb_neuron_layer_sequencer.sv
module tb_neuron_layer_sequencer;

    localparam int NI = 784;
    localparam int NN = 10;
    localparam int PASS_CYC = 787 * NN + 1;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic        busy, done, error;
    logic [9:0]  pix_addr;
    logic [15:0] pix_rdata;
    logic [12:0] w_addr;
    logic [15:0] w_rdata;
    logic [3:0]  b_addr;
    logic [15:0] b_rdata;
    logic        n_reset, n_inp_ready;
    logic [15:0] n_inp_data, n_weight, n_bias;
    logic [7:0]  n_out;
    logic        n_out_ready;
    logic        res_we;
    logic [3:0]  res_addr;
    logic [7:0]  res_data;
    logic [3:0]  class_idx;
    logic [7:0]  class_score;

    neuron_layer_sequencer dut (
        .clk(clk), .reset(reset), .start(start),
        .busy(busy), .done(done), .error(error),
        .pix_addr(pix_addr), .pix_rdata(pix_rdata),
        .w_addr(w_addr), .w_rdata(w_rdata),
        .b_addr(b_addr), .b_rdata(b_rdata),
        .n_reset(n_reset), .n_inp_ready(n_inp_ready),
        .n_inp_data(n_inp_data), .n_weight(n_weight), .n_bias(n_bias),
        .n_out(n_out), .n_out_ready(n_out_ready),
        .res_we(res_we), .res_addr(res_addr), .res_data(res_data),
        .class_idx(class_idx), .class_score(class_score)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string nm, input int act, input int exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // ---------------- memories (synchronous read) ----------------
    logic [15:0] pix_mem [0:1023];
    logic [15:0] w_mem   [0:8191];
    logic [15:0] b_mem   [0:15];

    always @(posedge clk) begin
        pix_rdata <= pix_mem[pix_addr];
        w_rdata   <= w_mem[w_addr];
        b_rdata   <= b_mem[b_addr];
    end

    // ---------------- neuron model ----------------
    bit  stub_mode = 1'b0;
    int  stub_vals [NN];
    int  hang_k = -1;

    logic signed [39:0] acc;
    int nk, ncnt;
    logic signed [39:0] prod;
    assign prod = 40'($signed(n_inp_data) * $signed(n_weight));

    function automatic logic [7:0] real_out(input logic signed [39:0] s,
                                            input logic [15:0] b);
        logic signed [39:0] v;
        v = (s >>> 8) + $signed({{24{b[15]}}, b});
        v = v >>> 8;
        if (v < 0) return 8'd0;
        if (v > 255) return 8'd255;
        return v[7:0];
    endfunction

    always @(posedge clk) begin
        if (n_reset) begin
            acc         <= '0;
            ncnt        <= 0;
            nk          <= int'(b_addr);
            n_out_ready <= 1'b0;
        end else begin
            n_out_ready <= 1'b0;
            if (n_inp_ready) begin
                acc  <= acc + prod;
                ncnt <= ncnt + 1;
                if (ncnt == NI - 1 && nk != hang_k) begin
                    n_out_ready <= 1'b1;
                    n_out <= stub_mode ? 8'(stub_vals[nk]) : real_out(acc + prod, n_bias);
                end
            end
        end
    end

    // ---------------- scoreboard ----------------
    typedef struct {
        bit is_done;
        int addr;
        int data;
        int err;
        int cyc;
    } exp_t;
    exp_t sb[$];

    task automatic push_res(input int k, input int d);
        exp_t e;
        e.is_done = 1'b0; e.addr = k; e.data = d; e.err = 0; e.cyc = 0;
        sb.push_back(e);
    endtask

    task automatic push_done(input int idx, input int score, input int err, input int at);
        exp_t e;
        e.is_done = 1'b1; e.addr = idx; e.data = score; e.err = err; e.cyc = at;
        sb.push_back(e);
    endtask

    // ---------------- monitor ----------------
    int mcnt = 0;
    int mon_k = 0;
    bit prev_busy = 1'b0;
    int prev_w = 0, prev_p = 0, last_w = -1;

    always @(negedge clk) begin
        exp_t e;
        if (reset) begin
            mcnt = 0;
            prev_busy = 1'b0;
        end else begin
            if (n_inp_ready) begin
                chk("w_addr_seq", prev_w, mon_k * NI + mcnt);
                chk("pix_addr_seq", prev_p, mcnt);
                chk("n_weight_fwd", int'(n_weight), int'(w_mem[prev_w]));
                chk("n_inp_data_fwd", int'(n_inp_data), int'(pix_mem[prev_p]));
                chk("n_bias_hold", int'(n_bias), int'(b_mem[mon_k]));
                last_w = prev_w;
                mcnt++;
            end
            if (n_reset && busy) begin
                if (mcnt != 0) chk("inp_ready_len", mcnt, NI);
                mcnt  = 0;
                mon_k = prev_busy ? mon_k + 1 : 0;
                chk("b_addr_clear", int'(b_addr), mon_k);
            end
            if (res_we) begin
                if (sb.size() == 0) begin
                    n_tests++; n_fail++;
                    $display("FAIL unexpected_res_we: addr %0d data %0d (cycle %0d)",
                             res_addr, res_data, cyc);
                end else begin
                    e = sb.pop_front();
                    chk("res_kind", int'(e.is_done), 0);
                    chk("res_addr", int'(res_addr), e.addr);
                    chk("res_data", int'(res_data), e.data);
                end
            end
            if (done) begin
                chk("inp_ready_len_last", mcnt, NI);
                mcnt = 0;
                if (sb.size() == 0) begin
                    n_tests++; n_fail++;
                    $display("FAIL unexpected_done: idx %0d score %0d (cycle %0d)",
                             class_idx, class_score, cyc);
                end else begin
                    e = sb.pop_front();
                    chk("done_kind", int'(e.is_done), 1);
                    chk("done_cycle", cyc, e.cyc);
                    chk("class_idx", int'(class_idx), e.addr);
                    chk("class_score", int'(class_score), e.data);
                    chk("error_at_done", int'(error), e.err);
                    chk("busy_at_done", int'(busy), 0);
                end
            end
            prev_busy = busy;
            prev_w = int'(w_addr);
            prev_p = int'(pix_addr);
        end
    end

    // ---------------- stimulus ----------------
    int c0;

    task automatic step();
        @(posedge clk); #1;
    endtask

    task automatic step_to(input int target);
        while (cyc < target) step();
    endtask

    task automatic launch(input bit held);
        start = 1'b1;
        c0 = cyc;
        step();
        if (!held) start = 1'b0;
    endtask

    task automatic wait_sb(input int budget);
        int n = 0;
        while (sb.size() != 0 && n < budget) begin
            step();
            n++;
        end
        chk("sb_drained", sb.size(), 0);
    endtask

    task automatic set_stub(input int v0, input int v1, input int v2, input int v3,
                            input int v4, input int v5, input int v6, input int v7,
                            input int v8, input int v9);
        stub_vals[0] = v0; stub_vals[1] = v1; stub_vals[2] = v2; stub_vals[3] = v3;
        stub_vals[4] = v4; stub_vals[5] = v5; stub_vals[6] = v6; stub_vals[7] = v7;
        stub_vals[8] = v8; stub_vals[9] = v9;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        for (int a = 0; a < 1024; a++) pix_mem[a] = 16'h0100;
        for (int a = 0; a < 8192; a++) w_mem[a] = 16'h0000;
        for (int k = 0; k < 16; k++) b_mem[k] = 16'(k << 8);

        // Reset state
        step(); step(); step();
        @(negedge clk);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_error", int'(error), 0);
        chk("rst_res_we", int'(res_we), 0);
        chk("rst_n_inp_ready", int'(n_inp_ready), 0);
        chk("rst_pix_addr", int'(pix_addr), 0);
        chk("rst_w_addr", int'(w_addr), 0);
        chk("rst_b_addr", int'(b_addr), 0);
        chk("rst_class_idx", int'(class_idx), 0);
        chk("rst_class_score", int'(class_score), 0);
        chk("rst_n_bias", int'(n_bias), 0);
        chk("rst_n_reset", int'(n_reset), 1);
        step();
        reset = 1'b0;
        step();
        @(negedge clk);
        chk("idle_n_reset", int'(n_reset), 0);
        step();

        // Pass 1: computing neuron, zero weights, bias k<<8 -> output k
        stub_mode = 1'b0;
        for (int k = 0; k < NN; k++) push_res(k, k);
        push_done(9, 9, 0, cyc + PASS_CYC);
        launch(1'b0);
        wait_sb(PASS_CYC + 50);
        step();

        // Pass 2: stub outputs with a tie, non-trivial memory contents
        for (int a = 0; a < 1024; a++) pix_mem[a] = 16'(a * 7);
        for (int a = 0; a < 8192; a++) w_mem[a] = 16'(a) ^ 16'h1234;
        for (int k = 0; k < 16; k++) b_mem[k] = 16'(k * 16'h0111);
        stub_mode = 1'b1;
        set_stub(5, 9, 9, 3, 0, 0, 0, 0, 0, 0);
        for (int k = 0; k < NN; k++) push_res(k, stub_vals[k]);
        push_done(1, 9, 0, cyc + PASS_CYC);
        launch(1'b0);
        wait_sb(PASS_CYC + 50);
        chk("last_w_addr", last_w, NI * NN - 1);
        step();

        // Pass 3: neuron 3 never answers -> timeout
        hang_k = 3;
        for (int k = 0; k < 3; k++) push_res(k, stub_vals[k]);
        push_done(1, 9, 1, cyc + 3164);
        launch(1'b0);
        wait_sb(3300);
        step(); step();
        @(negedge clk);
        chk("error_held", int'(error), 1);
        chk("busy_after_timeout", int'(busy), 0);
        step();

        // Pass 4: accepted start clears error; reset during STREAM of k=5
        hang_k = -1;
        set_stub(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        for (int k = 0; k < 5; k++) push_res(k, 0);
        launch(1'b0);
        @(negedge clk);
        chk("error_cleared_on_start", int'(error), 0);
        chk("clear_n_reset", int'(n_reset), 1);
        step_to(c0 + 3936 + 100);
        chk("sb_before_abort", sb.size(), 0);
        reset = 1'b1;
        step(); step();
        reset = 1'b0;
        @(negedge clk);
        chk("abort_busy", int'(busy), 0);
        chk("abort_w_addr", int'(w_addr), 0);
        step(); step(); step(); step();
        // Restarted pass, all-zero outputs: index 0 must win with score 0
        for (int k = 0; k < NN; k++) push_res(k, 0);
        push_done(0, 0, 0, cyc + PASS_CYC);
        launch(1'b0);
        wait_sb(PASS_CYC + 50);
        step();

        // Pass 5: start held high the whole pass
        set_stub(3, 200, 255, 254, 0, 0, 0, 0, 0, 255);
        for (int k = 0; k < NN; k++) push_res(k, stub_vals[k]);
        push_done(2, 255, 0, cyc + PASS_CYC);
        launch(1'b1);
        step_to(c0 + PASS_CYC + 1);
        @(negedge clk);
        chk("held_sb_drained", sb.size(), 0);
        chk("held_restart_busy", int'(busy), 1);
        chk("held_restart_clear", int'(n_reset), 1);
        step();
        start = 1'b0;
        reset = 1'b1;
        step(); step();
        reset = 1'b0;
        step(); step(); step();
        @(negedge clk);
        chk("final_idle", int'(busy), 0);
        chk("final_sb_empty", sb.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
